bsg_mem_2r1w_sync_initiator: RTL and testbench

//  Request-side controller for a 2-read/1-write synchronous memory (1-cycle read latency).
//  - Accepts one write and two independent read request streams via valid/ready.
//  - Drives the memory's w/r0/r1 ports and never reads and writes the same address in one cycle.
//  - Returns read data per port through a 2-entry output buffer with valid/ready.
//  - Sits between pipeline logic (e.g. register-file read stage) and the memory instance.

---
 rtl/bsg_mem_2r1w_sync_initiator_pkg.sv | 19 +
 rtl/bsg_mem_2r1w_sync_initiator_rport.sv | 118 +++++++++++
 rtl/bsg_mem_2r1w_sync_initiator.sv | 120 ++++++++++++
 tb/tb_bsg_mem_2r1w_sync_initiator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mem_2r1w_sync_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bsg_mem_2r1w_sync_initiator_pkg
// Brief   : Shared types and constants for the 2r1w sync memory initiator.
// Revision: 1.0 - initial release
// ============================================================================
package bsg_mem_2r1w_sync_initiator_pkg;

    localparam int c_credit_w = 2;
    localparam logic [c_credit_w-1:0] c_max_credits = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage
`default_nettype wire

// File: rtl/bsg_mem_2r1w_sync_initiator_rport.sv
`default_nettype none
// ============================================================================
// Module  : bsg_mem_2r1w_sync_initiator_rport
// Brief   : One read port: credit gating, write-conflict bypass, 2-entry FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module bsg_mem_2r1w_sync_initiator_rport
    import bsg_mem_2r1w_sync_initiator_pkg::*;
#(
    parameter int width_p      = 32,
    parameter int els_p        = 32,
    parameter int addr_width_p = 5
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic [addr_width_p-1:0] addr_i,
    output logic                    ready_o,
    input  logic                    w_v_i,
    input  logic [addr_width_p-1:0] w_addr_i,
    input  logic [width_p-1:0]      w_data_i,
    output logic                    mem_v_o,
    output logic [addr_width_p-1:0] mem_addr_o,
    input  logic [width_p-1:0]      mem_data_i,
    output logic                    data_v_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    data_ready_i
);

    occ_e                  r_occ;
    occ_e                  w_occ_nxt;
    logic                  r_inflight;
    logic                  r_bypass;
    logic [width_p-1:0]    r_bypass_data;
    logic [width_p-1:0]    r_buf [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;

    logic [c_credit_w-1:0] w_cnt;
    logic                  w_accept;
    logic                  w_conflict;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_store;
    logic                  w_deq;
    logic                  w_has_data;
    logic [width_p-1:0]    w_push_data;

    assign w_cnt       = c_credit_w'(r_occ) + c_credit_w'(r_inflight);
    assign w_push      = r_inflight;
    assign w_push_data = r_bypass ? r_bypass_data : mem_data_i;
    assign w_has_data  = (r_occ != EMPTY);

    // Fall-through: an empty FIFO presents the arriving response directly.
    assign data_v_o = w_has_data | r_inflight;
    assign data_o   = w_has_data ? r_buf[r_rd_ptr] : (r_inflight ? w_push_data : '0);
    assign w_pop    = data_v_o & data_ready_i;

    assign ready_o    = reset_n_i & ((w_cnt < c_max_credits) | ((w_cnt == c_max_credits) & w_pop));
    assign w_accept   = v_i & ready_o;
    assign w_conflict = w_accept & w_v_i & (w_addr_i == addr_i);
    assign mem_v_o    = w_accept & ~w_conflict;
    assign mem_addr_o = mem_v_o ? addr_i : '0;

    assign w_store = w_push & ~(~w_has_data & w_pop);
    assign w_deq   = w_pop & w_has_data;

    always_comb begin
        w_occ_nxt = r_occ;
        case (r_occ)
            EMPTY:   if (w_push && !w_pop) w_occ_nxt = ONE;
            ONE:     if (w_push && !w_pop) w_occ_nxt = TWO;
                     else if (w_pop && !w_push) w_occ_nxt = EMPTY;
            TWO:     if (w_pop && !w_push) w_occ_nxt = ONE;
            default: w_occ_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_occ         <= EMPTY;
            r_inflight    <= 1'b0;
            r_bypass      <= 1'b0;
            r_bypass_data <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_buf[0]      <= '0;
            r_buf[1]      <= '0;
        end else begin
            r_occ      <= w_occ_nxt;
            r_inflight <= w_accept;
            r_bypass   <= w_conflict;
            if (w_conflict) begin
                r_bypass_data <= w_data_i;
            end
            if (w_store) begin
                r_buf[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(w_push && (r_occ == TWO) && !w_pop))
                else $error("rport: push into full buffer");
            assert (!v_i || (32'(addr_i) < els_p))
                else $error("rport: read address out of range");
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/bsg_mem_2r1w_sync_initiator.sv
`default_nettype none
// ============================================================================
// Module  : bsg_mem_2r1w_sync_initiator
// Brief   : Request-side controller for a 2-read/1-write synchronous memory.
// Revision: 1.0 - initial release
// ============================================================================
module bsg_mem_2r1w_sync_initiator
    import bsg_mem_2r1w_sync_initiator_pkg::*;
#(
    parameter  int width_p       = 32,
    parameter  int els_p         = 32,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    output logic                     w_ready_o,

    input  logic                     r0_v_i,
    input  logic [addr_width_lp-1:0] r0_addr_i,
    output logic                     r0_ready_o,
    output logic                     r0_data_v_o,
    output logic [width_p-1:0]       r0_data_o,
    input  logic                     r0_data_ready_i,

    input  logic                     r1_v_i,
    input  logic [addr_width_lp-1:0] r1_addr_i,
    output logic                     r1_ready_o,
    output logic                     r1_data_v_o,
    output logic [width_p-1:0]       r1_data_o,
    input  logic                     r1_data_ready_i,

    output logic                     mem_w_v_o,
    output logic [addr_width_lp-1:0] mem_w_addr_o,
    output logic [width_p-1:0]       mem_w_data_o,

    output logic                     mem_r0_v_o,
    output logic [addr_width_lp-1:0] mem_r0_addr_o,
    input  logic [width_p-1:0]       mem_r0_data_i,

    output logic                     mem_r1_v_o,
    output logic [addr_width_lp-1:0] mem_r1_addr_o,
    input  logic [width_p-1:0]       mem_r1_data_i
);

    logic r_w_ready;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_w_ready <= 1'b0;
        end else begin
            r_w_ready <= 1'b1;
        end
    end

    assign w_ready_o    = r_w_ready;
    assign mem_w_v_o    = w_v_i & r_w_ready;
    assign mem_w_addr_o = mem_w_v_o ? w_addr_i : '0;
    assign mem_w_data_o = mem_w_v_o ? w_data_i : '0;

    bsg_mem_2r1w_sync_initiator_rport #(
        .width_p      (width_p),
        .els_p        (els_p),
        .addr_width_p (addr_width_lp)
    ) u_rport0 (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .v_i          (r0_v_i),
        .addr_i       (r0_addr_i),
        .ready_o      (r0_ready_o),
        .w_v_i        (mem_w_v_o),
        .w_addr_i     (mem_w_addr_o),
        .w_data_i     (mem_w_data_o),
        .mem_v_o      (mem_r0_v_o),
        .mem_addr_o   (mem_r0_addr_o),
        .mem_data_i   (mem_r0_data_i),
        .data_v_o     (r0_data_v_o),
        .data_o       (r0_data_o),
        .data_ready_i (r0_data_ready_i)
    );

    bsg_mem_2r1w_sync_initiator_rport #(
        .width_p      (width_p),
        .els_p        (els_p),
        .addr_width_p (addr_width_lp)
    ) u_rport1 (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .v_i          (r1_v_i),
        .addr_i       (r1_addr_i),
        .ready_o      (r1_ready_o),
        .w_v_i        (mem_w_v_o),
        .w_addr_i     (mem_w_addr_o),
        .w_data_i     (mem_w_data_o),
        .mem_v_o      (mem_r1_v_o),
        .mem_addr_o   (mem_r1_addr_o),
        .mem_data_i   (mem_r1_data_i),
        .data_v_o     (r1_data_v_o),
        .data_o       (r1_data_o),
        .data_ready_i (r1_data_ready_i)
    );

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!w_v_i || (32'(w_addr_i) < els_p))
                else $error("initiator: write address out of range");
            assert (!(mem_w_v_o && mem_r0_v_o && (mem_r0_addr_o == mem_w_addr_o)))
                else $error("initiator: r0 and w hit the same address");
            assert (!(mem_w_v_o && mem_r1_v_o && (mem_r1_addr_o == mem_w_addr_o)))
                else $error("initiator: r1 and w hit the same address");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_mem_2r1w_sync_initiator.sv
`default_nettype none
// ============================================================================
// Module  : tb_bsg_mem_2r1w_sync_initiator
// Brief   : Directed and randomized checks of the 2r1w sync memory initiator.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bsg_mem_2r1w_sync_initiator;

    localparam int W  = 32;
    localparam int N  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          w_v, r0_v, r1_v, r0_data_ready, r1_data_ready;
    logic [AW-1:0] w_addr, r0_addr, r1_addr;
    logic [W-1:0]  w_data;
    logic          w_ready, r0_ready, r1_ready, r0_data_v, r1_data_v;
    logic [W-1:0]  r0_data, r1_data;
    logic          mem_w_v, mem_r0_v, mem_r1_v;
    logic [AW-1:0] mem_w_addr, mem_r0_addr, mem_r1_addr;
    logic [W-1:0]  mem_w_data;
    logic [W-1:0]  mem_r0_data = '0;
    logic [W-1:0]  mem_r1_data = '0;

    logic [W-1:0]  mem [N];
    logic [W-1:0]  sh  [N];
    logic [W-1:0]  q0 [$];
    logic [W-1:0]  q1 [$];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    bsg_mem_2r1w_sync_initiator #(.width_p(W), .els_p(N)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .w_v_i           (w_v),
        .w_addr_i        (w_addr),
        .w_data_i        (w_data),
        .w_ready_o       (w_ready),
        .r0_v_i          (r0_v),
        .r0_addr_i       (r0_addr),
        .r0_ready_o      (r0_ready),
        .r0_data_v_o     (r0_data_v),
        .r0_data_o       (r0_data),
        .r0_data_ready_i (r0_data_ready),
        .r1_v_i          (r1_v),
        .r1_addr_i       (r1_addr),
        .r1_ready_o      (r1_ready),
        .r1_data_v_o     (r1_data_v),
        .r1_data_o       (r1_data),
        .r1_data_ready_i (r1_data_ready),
        .mem_w_v_o       (mem_w_v),
        .mem_w_addr_o    (mem_w_addr),
        .mem_w_data_o    (mem_w_data),
        .mem_r0_v_o      (mem_r0_v),
        .mem_r0_addr_o   (mem_r0_addr),
        .mem_r0_data_i   (mem_r0_data),
        .mem_r1_v_o      (mem_r1_v),
        .mem_r1_addr_o   (mem_r1_addr),
        .mem_r1_data_i   (mem_r1_data)
    );

    // Synchronous 2r1w memory with 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_r0_v) mem_r0_data <= mem[mem_r0_addr];
        if (mem_r1_v) mem_r1_data <= mem[mem_r1_addr];
        if (mem_w_v)  mem[mem_w_addr] <= mem_w_data;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            mem[i] = '0;
            sh[i]  = '0;
        end
        reset_n = 1'b0;
        w_v = 1'b1; w_addr = 5'd3; w_data = 32'h55;
        r0_v = 1'b1; r0_addr = 5'd3; r1_v = 1'b1; r1_addr = 5'd4;
        r0_data_ready = 1'b1; r1_data_ready = 1'b1;

        // Reset held with all requests valid
        repeat (3) @(posedge clk);
        #2;
        chk("rst_w_ready",  32'(w_ready), 0);
        chk("rst_r0_ready", 32'(r0_ready), 0);
        chk("rst_r1_ready", 32'(r1_ready), 0);
        chk("rst_r0_dv",    32'(r0_data_v), 0);
        chk("rst_r1_dv",    32'(r1_data_v), 0);
        chk("rst_mem_w_v",  32'(mem_w_v), 0);
        chk("rst_mem_r0_v", 32'(mem_r0_v), 0);
        chk("rst_mem_r1_v", 32'(mem_r1_v), 0);
        chk("rst_r0_data",  r0_data, 0);
        w_v = 1'b0; r0_v = 1'b0; r1_v = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("rel_w_ready",  32'(w_ready), 1);
        chk("rel_r0_ready", 32'(r0_ready), 1);
        chk("rel_r1_ready", 32'(r1_ready), 1);

        // Fill memory with A[i] = i*3
        for (int i = 0; i < N; i++) begin
            w_v = 1'b1; w_addr = 5'(i); w_data = 32'(i * 3);
            #1;
            if (i == 0) chk("fill_mem_w_v", 32'(mem_w_v), 1);
            sh[i] = 32'(i * 3);
            step();
        end
        w_v = 1'b0;

        // Back-to-back streaming on r0, one response per cycle at latency 1
        for (int k = 0; k <= 33; k++) begin
            r0_v = (k < N); r0_addr = 5'(k);
            #1;
            if (k == 0) chk("stream_lat0", 32'(r0_data_v), 0);
            if (k < N)  chk("stream_rdy", 32'(r0_ready), 1);
            if (k >= 1 && k <= N) begin
                chk("stream_dv", 32'(r0_data_v), 1);
                chk("stream_data", r0_data, 32'((k - 1) * 3));
            end
            if (k == 33) chk("stream_idle", 32'(r0_data_v), 0);
            step();
        end

        // Write and both reads to the same address in one cycle
        w_v = 1'b1; w_addr = 5'd5; w_data = 32'hDEAD;
        r0_v = 1'b1; r0_addr = 5'd5; r1_v = 1'b1; r1_addr = 5'd5;
        #1;
        chk("cfl_mem_r0_v", 32'(mem_r0_v), 0);
        chk("cfl_mem_r1_v", 32'(mem_r1_v), 0);
        chk("cfl_mem_w_v",  32'(mem_w_v), 1);
        sh[5] = 32'hDEAD;
        step();
        w_v = 1'b0; r0_v = 1'b0; r1_v = 1'b0;
        #1;
        chk("cfl_r0_dv",   32'(r0_data_v), 1);
        chk("cfl_r0_data", r0_data, 32'hDEAD);
        chk("cfl_r1_dv",   32'(r1_data_v), 1);
        chk("cfl_r1_data", r1_data, 32'hDEAD);
        step();

        // Read one cycle after a write goes to memory and sees the new value
        w_v = 1'b1; w_addr = 5'd7; w_data = 32'h1234;
        sh[7] = 32'h1234;
        step();
        w_v = 1'b0; r1_v = 1'b1; r1_addr = 5'd7;
        #1;
        chk("raw_mem_r1_v",    32'(mem_r1_v), 1);
        chk("raw_mem_r1_addr", 32'(mem_r1_addr), 7);
        step();
        r1_v = 1'b0;
        #1;
        chk("raw_r1_data", r1_data, 32'h1234);
        step();

        // Backpressure on r1: two credits, then stall, then drain in order
        r1_data_ready = 1'b0;
        r1_v = 1'b1; r1_addr = 5'd10;
        #1; chk("bp_a_rdy", 32'(r1_ready), 1); step();
        r1_addr = 5'd11;
        #1; chk("bp_b_rdy", 32'(r1_ready), 1); chk("bp_b_data", r1_data, 30); step();
        r1_addr = 5'd12;
        #1; chk("bp_c_rdy", 32'(r1_ready), 0); chk("bp_c_data", r1_data, 30); step();
        #1; chk("bp_c2_rdy", 32'(r1_ready), 0); chk("bp_c2_data", r1_data, 30); step();
        r1_data_ready = 1'b1;
        #1; chk("bp_d_rdy", 32'(r1_ready), 1); chk("bp_d_data", r1_data, 30); step();
        r1_addr = 5'd13;
        #1; chk("bp_e_rdy", 32'(r1_ready), 1); chk("bp_e_data", r1_data, 33); step();
        r1_v = 1'b0;
        #1; chk("bp_f_data", r1_data, 36); step();
        #1; chk("bp_g_data", r1_data, 39); step();
        #1; chk("bp_h_dv", 32'(r1_data_v), 0); step();

        // Random mixed traffic against a write-first reference
        for (int c = 0; c < 2000; c++) begin
            w_v = 1'($urandom_range(0, 1)); w_addr = 5'($urandom_range(0, 7)); w_data = $urandom;
            r0_v = 1'($urandom_range(0, 1)); r0_addr = 5'($urandom_range(0, 7));
            r1_v = 1'($urandom_range(0, 1)); r1_addr = 5'($urandom_range(0, 7));
            r0_data_ready = ($urandom_range(0, 3) != 0);
            r1_data_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (r0_data_v && r0_data_ready) begin
                if (q0.size() == 0) chk("rand_r0_extra", 32'(r0_data_v), 0);
                else chk("rand_r0_data", r0_data, q0.pop_front());
            end
            if (r1_data_v && r1_data_ready) begin
                if (q1.size() == 0) chk("rand_r1_extra", 32'(r1_data_v), 0);
                else chk("rand_r1_data", r1_data, q1.pop_front());
            end
            if (r0_v && r0_ready)
                q0.push_back((w_v && w_ready && w_addr == r0_addr) ? w_data : sh[r0_addr]);
            if (r1_v && r1_ready)
                q1.push_back((w_v && w_ready && w_addr == r1_addr) ? w_data : sh[r1_addr]);
            if (w_v && w_ready) sh[w_addr] = w_data;
            step();
        end
        w_v = 1'b0; r0_v = 1'b0; r1_v = 1'b0;
        r0_data_ready = 1'b1; r1_data_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (r0_data_v) begin
                if (q0.size() == 0) chk("drain_r0_extra", 32'(r0_data_v), 0);
                else chk("drain_r0_data", r0_data, q0.pop_front());
            end
            if (r1_data_v) begin
                if (q1.size() == 0) chk("drain_r1_extra", 32'(r1_data_v), 0);
                else chk("drain_r1_data", r1_data, q1.pop_front());
            end
            step();
        end
        chk("drain_q0_left", 32'(q0.size()), 0);
        chk("drain_q1_left", 32'(q1.size()), 0);

        // Reset while r0 holds one buffered and one in-flight read
        r0_data_ready = 1'b0;
        r0_v = 1'b1; r0_addr = 5'd1; step();
        r0_addr = 5'd2; step();
        r0_v = 1'b0;
        #1;
        chk("mid_pre_dv", 32'(r0_data_v), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_dv",    32'(r0_data_v), 0);
        chk("mid_rst_rdy",   32'(r0_ready), 0);
        chk("mid_rst_wrdy",  32'(w_ready), 0);
        chk("mid_rst_data",  r0_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        r0_data_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("mid_no_stale", 32'(r0_data_v), 0);
        end
        r0_v = 1'b1; r0_addr = 5'd3;
        step();
        r0_v = 1'b0;
        #1;
        chk("mid_after_dv",   32'(r0_data_v), 1);
        chk("mid_after_data", r0_data, sh[3]);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
